traffic_ctrl_n: RTL and testbench
=================================

# traffic_ctrl_n

Parametrised N-approach traffic light controller with four phases: GREEN, YELLOW, ALL_RED and an optional PREP (red+yellow) phase. Each approach has a car-presence sensor. The controller serves approaches in round-robin order and skips approaches with no demand. Green is bounded below by MIN_GREEN, gapped out when the served sensor clears, and force-ended at MAX_GREEN. When no other approach has demand, green rests on the current approach. The block sits in the intersection top level, driven by a system clock plus a 1 Hz `tick` enable from the clock-divider block.

## Interface
- NUM_ROADS, 4: number of approaches, legal range 2..8
- MIN_GREEN, 5: minimum green length in ticks, ≥1
- MAX_GREEN, 20: maximum green length in ticks while other demand exists, ≥MIN_GREEN
- YELLOW, 3: yellow length in ticks, ≥1
- ALL_RED, 1: all-red clearance length in ticks, ≥1
- PREP, 1: red+yellow length shown on the incoming approach, in ticks; 0 skips the phase

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- tick  in  1  timing enable; all phase counting advances only on cycles where tick=1
- sensor  in  NUM_ROADS  bit i=1 means a car is present at approach i; already synchronised upstream
- light  out  2*NUM_ROADS  bits [2i+1:2i] give the light for approach i: 00 green, 01 yellow, 10 red
- road_idx  out  IDX_W=max(1,$clog2(NUM_ROADS))  approach currently owning the phase
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 PREP
- phase_chg  out  1  registered, high for the first cycle of every new phase

## Operation
- State registers:
  - phase
  - road `r` (current approach)
  - `nxt` (the chosen incoming approach, valid in PREP)
  - duration counter `cnt`
- Outputs are Moore-decoded from the registered state, with one exception: phase_chg is itself a register.
- Reset values:
  - phase=GREEN, r=0, cnt=0, phase_chg=0
  - light: approach 0 = 00, all other approaches = 10
- Light mapping per phase:
  - GREEN: approach r=00, others 10.
  - YELLOW: approach r=01, others 10.
  - ALL_RED: all approaches 10.
  - PREP: approach nxt=01, others 10.
- Definitions used below:
  - other_demand = OR of sensor[j] for all j≠r.
  - g = cnt+1 (number of ticks completed in this green, including the current one).
- GREEN, on a tick:
  - Exit to YELLOW when all of these hold: g≥MIN_GREEN, other_demand=1, and (sensor[r]=0 or g≥MAX_GREEN).
  - Otherwise cnt increments and saturates at MAX_GREEN-1.
- YELLOW, ALL_RED and PREP (phase length D), on a tick:
  - If cnt==D-1: leave the phase and set cnt=0.
  - Otherwise: cnt increments.
- Sequence: GREEN → YELLOW → ALL_RED → PREP (skipped when PREP=0) → GREEN on nxt.
- Choosing nxt:
  - nxt is computed on the tick that ends ALL_RED.
  - It is the first j in cyclic order r+1 … r+NUM_ROADS-1 with sensor[j]=1.
  - If no such j exists (demand vanished), nxt=(r+1) mod NUM_ROADS.
- Entering GREEN sets r=nxt and cnt=0.
- Wrap-around: index NUM_ROADS-1 is followed by index 0.
- Counter width is $clog2(max of all durations)+1. Bit widths are derived internally.

## Timing
- One state change per tick at most. Outputs update on the clk edge on which tick is sampled.
- A phase of length D stays visible for exactly D ticks. With tick held high, that is D clk cycles.
- Green length:
  - With competing demand and the served sensor clear: MIN_GREEN ticks.
  - With competing demand and the served sensor held: MAX_GREEN ticks.
  - With no other demand: unbounded.
- Sensors are sampled only on tick cycles. Sensor pulses between ticks are ignored.
- reset has priority over tick in the same cycle. Asserting reset mid-phase returns the block immediately (asynchronously) to the reset state. The first tick after release counts as green tick 1 for approach 0.
- A sensor change on the exit tick is honoured: the exit decision uses that same cycle's value.

## Test plan
- Rest in green: reset, sensor=0000, tick=1 for 50 cycles → light=8'b10101000, phase=00 and road_idx=0 on every cycle.
- Skip empty approach: sensor=0100 from reset, tick=1 → sequence:
  - 5 cycles of road 0 GREEN
  - 3 YELLOW (light[1:0]=01)
  - 1 ALL_RED (8'b10101010)
  - 1 PREP (light[5:4]=01)
  - then road_idx=2 GREEN
  - road 1 is never served; phase_chg pulses on each boundary.
- Max green: sensor=0011 held, tick=1 → road 0 GREEN for exactly 20 cycles, then YELLOW; after the full transition road_idx=1.
- Tick gating: tick pulsed once every 4 cycles, sensor=0010 → road 0 green lasts 20 cycles and yellow lasts 12 cycles; no state changes on non-tick cycles.
- Wrap-around and vanished demand:
  - With r=3 and sensor=0001: next served approach is 0.
  - Repeat with r=3, but drop sensor to 0000 during ALL_RED: next served approach is still 0 (r+1 fallback).
  - Repeat from r=1, dropping demand in ALL_RED: next served approach is 2.
- Reset mid-operation: assert reset during YELLOW of road 2 → the same cycle shows light=8'b10101000, phase=00, road_idx=0, phase_chg=0; after release the green counts from tick 1.

Source files
------------

// File: rtl/traffic_ctrl_n.sv
// N-approach round-robin traffic light controller with demand skipping,
// min/max green, gap-out, yellow, all-red clearance and optional red+yellow prep.
module traffic_ctrl_n #(
  parameter  int NUM_ROADS = 4,
  parameter  int MIN_GREEN = 5,
  parameter  int MAX_GREEN = 20,
  parameter  int YELLOW    = 3,
  parameter  int ALL_RED   = 1,
  parameter  int PREP      = 1,
  localparam int IDX_W     = ($clog2(NUM_ROADS) > 1) ? $clog2(NUM_ROADS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [NUM_ROADS-1:0]   sensor,
  output logic [2*NUM_ROADS-1:0] light,
  output logic [IDX_W-1:0]       road_idx,
  output logic [1:0]             phase,
  output logic                   phase_chg
);

  localparam int MAX_D1  = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
  localparam int MAX_D2  = (MAX_D1 > ALL_RED) ? MAX_D1 : ALL_RED;
  localparam int MAX_DUR = (MAX_D2 > PREP) ? MAX_D2 : PREP;
  localparam int CNT_W   = $clog2(MAX_DUR) + 1;

  localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G_C   = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] PREP_LAST = CNT_W'((PREP > 0) ? PREP - 1 : 0);
  localparam logic [IDX_W:0]   NR_C      = (IDX_W+1)'(NUM_ROADS);

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_ALL_RED = 2'b10,
    PH_PREP    = 2'b11
  } phase_t;

  phase_t             phase_q, phase_d;
  logic [IDX_W-1:0]   r_q, r_d;
  logic [IDX_W-1:0]   nxt_q, nxt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               chg_q;

  logic [CNT_W-1:0]     g;
  logic [NUM_ROADS-1:0] own;
  logic                 other_demand;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W:0]       wrap_sum;
  logic [IDX_W-1:0]     lit_idx;
  logic [1:0]           lit_val;

  assign g = cnt_q + CNT_W'(1);

  // Round-robin search: scanning downward so the nearest demanding approach wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    own      = '0;
    own[r_q] = 1'b1;
    other_demand = |(sensor & ~own);

    wrap_sum = {1'b0, r_q} + (IDX_W+1)'(1);
    if (wrap_sum >= NR_C) wrap_sum = wrap_sum - NR_C;
    pick = wrap_sum[IDX_W-1:0];
    for (int k = NUM_ROADS - 1; k >= 1; k--) begin
      wrap_sum = {1'b0, r_q} + (IDX_W+1)'(k);
      if (wrap_sum >= NR_C) wrap_sum = wrap_sum - NR_C;
      if (sensor[wrap_sum[IDX_W-1:0]]) pick = wrap_sum[IDX_W-1:0];
    end
  end

  always_comb begin
    phase_d = phase_q;
    r_d     = r_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (phase_q)
        PH_GREEN: begin
          if (g >= MIN_G_C && other_demand && (!sensor[r_q] || g >= MAX_G_C)) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = (g >= MAX_G_C) ? cnt_q : g;
          end
        end
        PH_YELLOW: begin
          if (cnt_q == YEL_LAST) begin
            phase_d = PH_ALL_RED;
            cnt_d   = '0;
          end else begin
            cnt_d = g;
          end
        end
        PH_ALL_RED: begin
          if (cnt_q == AR_LAST) begin
            nxt_d = pick;
            cnt_d = '0;
            if (PREP > 0) begin
              phase_d = PH_PREP;
            end else begin
              phase_d = PH_GREEN;
              r_d     = pick;
            end
          end else begin
            cnt_d = g;
          end
        end
        PH_PREP: begin
          if (cnt_q == PREP_LAST) begin
            phase_d = PH_GREEN;
            r_d     = nxt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = g;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_GREEN;
      r_q     <= '0;
      nxt_q   <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      phase_q <= phase_d;
      r_q     <= r_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      chg_q   <= (phase_d != phase_q);
    end
  end

  // PREP shows red+yellow on the incoming approach, not the one being cleared.
  always_comb begin
    lit_idx = (phase_q == PH_PREP) ? nxt_q : r_q;
    unique case (phase_q)
      PH_GREEN:   lit_val = 2'b00;
      PH_YELLOW:  lit_val = 2'b01;
      PH_ALL_RED: lit_val = 2'b10;
      PH_PREP:    lit_val = 2'b01;
    endcase
    light = {NUM_ROADS{2'b10}};
    for (int i = 0; i < NUM_ROADS; i++) begin
      if (IDX_W'(i) == lit_idx) light[2*i +: 2] = lit_val;
    end
  end

  assign road_idx  = r_q;
  assign phase     = phase_q;
  assign phase_chg = chg_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n (default parameters, 4 approaches) using an
// expected-value queue drained by a monitor on the falling clock edge.
module tb_traffic_ctrl_n;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, AR = 2'b10, PR = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] sensor;
  logic [7:0] light;
  logic [1:0] road_idx;
  logic [1:0] phase;
  logic       phase_chg;

  typedef struct {
    string      nm;
    logic [7:0] light;
    logic [1:0] phase;
    int         road;   // -1: not compared
    logic       chg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_ctrl_n dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .sensor    (sensor),
    .light     (light),
    .road_idx  (road_idx),
    .phase     (phase),
    .phase_chg (phase_chg)
  );

  always #5 clk = ~clk;

  // All approaches red except idx, which shows v.
  function automatic logic [7:0] lt(input int idx, input logic [1:0] v);
    logic [7:0] x;
    x = 8'b10101010;
    if (idx >= 0) x[2*idx +: 2] = v;
    return x;
  endfunction

  // Monitor: the DUT presents its state every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (light !== e.light || phase !== e.phase || phase_chg !== e.chg ||
            (e.road >= 0 && int'(road_idx) != e.road)) begin
          errors++;
          $display("FAIL %s: got light=%b phase=%b road=%0d chg=%b, want light=%b phase=%b road=%0d chg=%b",
                   e.nm, light, phase, road_idx, phase_chg, e.light, e.phase, e.road, e.chg);
        end
      end
    end
  end

  // n cycles of one phase; tick on every per-th cycle; phase_chg expected on cycle 0 only if chg0.
  task automatic ph(input string nm, input int n, input logic [1:0] p, input int road,
                    input int lidx, input logic [1:0] lv, input logic [3:0] s,
                    input int per, input bit chg0);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.nm    = $sformatf("%s[%0d]", nm, k);
      e.light = lt(lidx, lv);
      e.phase = p;
      e.road  = road;
      e.chg   = (k == 0) ? chg0 : 1'b0;
      tick    = ((k % per) == per - 1);
      sensor  = s;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic push_reset_state(input string nm);
    exp_t e;
    e.nm = nm; e.light = 8'b10101000; e.phase = G; e.road = 0; e.chg = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1; tick = 1'b0; sensor = 4'b0000;
    push_reset_state(nm);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic reach_r3(input string nm);
    do_reset({nm, "_rst"});
    ph({nm, "_g0"}, 5, G,  0, 0,  2'b00, 4'b1000, 1, 1'b0);
    ph({nm, "_y0"}, 3, Y,  0, 0,  2'b01, 4'b1000, 1, 1'b1);
    ph({nm, "_ar"}, 1, AR, 0, -1, 2'b10, 4'b1000, 1, 1'b1);
    ph({nm, "_pr"}, 1, PR, -1, 3, 2'b01, 4'b1000, 1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; sensor = 4'b0000;
    @(posedge clk); #1;

    // Rest in green with no demand anywhere.
    do_reset("rest_rst");
    ph("rest_g0", 50, G, 0, 0, 2'b00, 4'b0000, 1, 1'b0);

    // Road 1 empty is skipped; road 2 served after prep.
    do_reset("skip_rst");
    ph("skip_g0", 5, G,  0, 0,  2'b00, 4'b0100, 1, 1'b0);
    ph("skip_y0", 3, Y,  0, 0,  2'b01, 4'b0100, 1, 1'b1);
    ph("skip_ar", 1, AR, 0, -1, 2'b10, 4'b0100, 1, 1'b1);
    ph("skip_pr", 1, PR, -1, 2, 2'b01, 4'b0100, 1, 1'b1);
    ph("skip_g2", 5, G,  2, 2,  2'b00, 4'b0100, 1, 1'b1);

    // Served sensor held: green force-ended at MAX_GREEN.
    do_reset("max_rst");
    ph("max_g0", 20, G,  0, 0,  2'b00, 4'b0011, 1, 1'b0);
    ph("max_y0", 3,  Y,  0, 0,  2'b01, 4'b0011, 1, 1'b1);
    ph("max_ar", 1,  AR, 0, -1, 2'b10, 4'b0011, 1, 1'b1);
    ph("max_pr", 1,  PR, -1, 1, 2'b01, 4'b0011, 1, 1'b1);
    ph("max_g1", 3,  G,  1, 1,  2'b00, 4'b0011, 1, 1'b1);

    // Tick every 4th cycle: all phase lengths scale by 4.
    do_reset("gate_rst");
    ph("gate_g0", 20, G,  0, 0,  2'b00, 4'b0010, 4, 1'b0);
    ph("gate_y0", 12, Y,  0, 0,  2'b01, 4'b0010, 4, 1'b1);
    ph("gate_ar", 4,  AR, 0, -1, 2'b10, 4'b0010, 4, 1'b1);
    ph("gate_pr", 4,  PR, -1, 1, 2'b01, 4'b0010, 4, 1'b1);
    ph("gate_g1", 4,  G,  1, 1,  2'b00, 4'b0010, 4, 1'b1);

    // Wrap 3 -> 0 with demand on 0.
    reach_r3("wa");
    ph("wa_g3", 5, G,  3, 3,  2'b00, 4'b0001, 1, 1'b1);
    ph("wa_y3", 3, Y,  3, 3,  2'b01, 4'b0001, 1, 1'b1);
    ph("wa_ar", 1, AR, 3, -1, 2'b10, 4'b0001, 1, 1'b1);
    ph("wa_pr", 1, PR, -1, 0, 2'b01, 4'b0001, 1, 1'b1);
    ph("wa_g0", 2, G,  0, 0,  2'b00, 4'b0001, 1, 1'b1);

    // Demand on 2 vanishes in ALL_RED: fallback is r+1 = 0, not 2.
    reach_r3("wb");
    ph("wb_g3", 5, G,  3, 3,  2'b00, 4'b0100, 1, 1'b1);
    ph("wb_y3", 3, Y,  3, 3,  2'b01, 4'b0100, 1, 1'b1);
    ph("wb_ar", 1, AR, 3, -1, 2'b10, 4'b0000, 1, 1'b1);
    ph("wb_pr", 1, PR, -1, 0, 2'b01, 4'b0000, 1, 1'b1);
    ph("wb_g0", 2, G,  0, 0,  2'b00, 4'b0000, 1, 1'b1);

    // From r=1, demand on 3 vanishes in ALL_RED: fallback is 2.
    do_reset("wc_rst");
    ph("wc_g0", 5, G,  0, 0,  2'b00, 4'b0010, 1, 1'b0);
    ph("wc_y0", 3, Y,  0, 0,  2'b01, 4'b0010, 1, 1'b1);
    ph("wc_ar0", 1, AR, 0, -1, 2'b10, 4'b0010, 1, 1'b1);
    ph("wc_pr1", 1, PR, -1, 1, 2'b01, 4'b0010, 1, 1'b1);
    ph("wc_g1", 5, G,  1, 1,  2'b00, 4'b1000, 1, 1'b1);
    ph("wc_y1", 3, Y,  1, 1,  2'b01, 4'b1000, 1, 1'b1);
    ph("wc_ar1", 1, AR, 1, -1, 2'b10, 4'b0000, 1, 1'b1);
    ph("wc_pr2", 1, PR, -1, 2, 2'b01, 4'b0000, 1, 1'b1);
    ph("wc_g2", 2, G,  2, 2,  2'b00, 4'b0000, 1, 1'b1);

    // Asynchronous reset during yellow of road 2, with tick high.
    do_reset("mr_rst");
    ph("mr_g0", 5, G,  0, 0,  2'b00, 4'b0100, 1, 1'b0);
    ph("mr_y0", 3, Y,  0, 0,  2'b01, 4'b0100, 1, 1'b1);
    ph("mr_ar", 1, AR, 0, -1, 2'b10, 4'b0100, 1, 1'b1);
    ph("mr_pr", 1, PR, -1, 2, 2'b01, 4'b0100, 1, 1'b1);
    ph("mr_g2", 5, G,  2, 2,  2'b00, 4'b0001, 1, 1'b1);
    ph("mr_y2", 1, Y,  2, 2,  2'b01, 4'b0001, 1, 1'b1);
    reset = 1'b1; tick = 1'b1; sensor = 4'b0001;
    push_reset_state("mr_async");
    @(posedge clk); #1;
    reset = 1'b0;
    ph("mr_after_g0", 5, G, 0, 0, 2'b00, 4'b0100, 1, 1'b0);
    ph("mr_after_y0", 1, Y, 0, 0, 2'b01, 4'b0100, 1, 1'b1);

    tick = 1'b0;
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
